// File: rtl/fifo_sync_if.sv
// fifo_sync handshake bundle: write/read requests, flush, error clear,
// head data and occupancy/error flags.
interface fifo_sync_if #(
  parameter int DataWidth = 8,
  parameter int Depth     = 8
);
  localparam int CountWidth = $clog2(Depth) + 1;

  logic                  i_flush;
  logic                  i_wr_en;
  logic [DataWidth-1:0]  i_wr_data;
  logic                  i_rd_en;
  logic                  i_err_clr;
  logic [DataWidth-1:0]  o_rd_data;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_almost_full;
  logic                  o_almost_empty;
  logic [CountWidth-1:0] o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_flush, i_wr_en, i_wr_data,
    output i_rd_en, i_err_clr,
    input  o_rd_data, o_full, o_empty,
    input  o_almost_full, o_almost_empty,
    input  o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wr_en, i_wr_data,
    input  i_rd_en, i_err_clr,
    output o_rd_data, o_full, o_empty,
    output o_almost_full, o_almost_empty,
    output o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered occupancy.
// Sticky overflow/underflow flags exist only with FIFO_SYNC_ERR_FLAGS_EN.
module fifo_sync #(
  parameter int DataWidth         = 8,
  parameter int Depth             = 8,
  parameter int AlmostFullThresh  = Depth - 2,
  parameter int AlmostEmptyThresh = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  fifo_sync_if.slave bus
);
  localparam int AddrWidth  = $clog2(Depth);
  localparam int CountWidth = AddrWidth + 1;

  typedef logic [AddrWidth:0]    ptr_t;
  typedef logic [CountWidth-1:0] cnt_t;

  logic [DataWidth-1:0] mem_q [Depth];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  assign full  = count_q == cnt_t'(Depth);
  assign empty = count_q == '0;

  // a pop frees a slot, so a full FIFO still takes a same-cycle write
  assign rd_acc = bus.i_rd_en & ~empty & ~bus.i_flush;
  assign wr_acc = bus.i_wr_en & (~full | rd_acc)
                & ~bus.i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AddrWidth-1:0]] <= bus.i_wr_data;
    end
  end

  assign bus.o_rd_data = mem_q[rd_ptr_q[AddrWidth-1:0]];
  assign bus.o_count   = count_q;
  assign bus.o_full    = full;
  assign bus.o_empty   = empty;
  assign bus.o_almost_full =
    count_q >= cnt_t'(AlmostFullThresh);
  assign bus.o_almost_empty =
    count_q <= cnt_t'(AlmostEmptyThresh);

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic ovf_set;
  logic unf_set;

  // empty with a same-cycle write is a legal pass-through, not underflow
  assign ovf_set = bus.i_wr_en & ~wr_acc & ~bus.i_flush;
  assign unf_set = bus.i_rd_en & empty & ~bus.i_wr_en
                 & ~bus.i_flush;

  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~bus.i_err_clr);
    unf_d = unf_set | (unf_q & ~bus.i_err_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr  = bus.i_err_clr;
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// Randomized self-checking bench for fifo_sync against a queue model.
// Error-flag expectations follow FIFO_SYNC_ERR_FLAGS_EN.
module tb_fifo_sync;
  localparam int Depth = 8;
  localparam int AfTh  = 6;
  localparam int AeTh  = 2;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_unf;

  fifo_sync_if #(.DataWidth(8), .Depth(Depth)) bus ();

  fifo_sync #(
    .DataWidth(8),
    .Depth(Depth),
    .AlmostFullThresh(AfTh),
    .AlmostEmptyThresh(AeTh)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.i_flush   = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_rd_en   = 1'b0;
    bus.i_err_clr = 1'b0;
  endtask

  task automatic drive_cycle(input bit wr, input logic [7:0] d,
                             input bit rd, input bit fl,
                             input bit clr);
    bit is_full;
    bit is_empty;
    bit rd_ok;
    bit wr_ok;
    bit ovf_set;
    bit unf_set;
    bus.i_wr_en   = wr;
    bus.i_wr_data = d;
    bus.i_rd_en   = rd;
    bus.i_flush   = fl;
    bus.i_err_clr = clr;
    is_full  = q.size() == Depth;
    is_empty = q.size() == 0;
    rd_ok    = rd && !is_empty && !fl;
    wr_ok    = wr && (!is_full || rd_ok) && !fl;
    ovf_set  = wr && !wr_ok && !fl;
    unf_set  = rd && is_empty && !wr && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(d);
    end
    if (ErrEn) begin
      m_ovf = ovf_set || (m_ovf && !clr);
      m_unf = unf_set || (m_unf && !clr);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (bus.o_count !== 4'd0) begin
      failures++;
      $display("FAIL rst_count got %0d want 0", bus.o_count);
    end
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0) begin
      failures++;
      $display("FAIL rst_empty_full got %b%b want 10",
               bus.o_empty, bus.o_full);
    end
    checks++;
    if (bus.o_almost_empty !== 1'b1
        || bus.o_almost_full !== 1'b0) begin
      failures++;
      $display("FAIL rst_almost got %b%b want 10",
               bus.o_almost_empty, bus.o_almost_full);
    end
    checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_err got %b%b want 00",
               bus.o_overflow, bus.o_underflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= Depth + 1; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.o_count !== 4'(q.size())) begin
        failures++;
        $display("FAIL fill_count got %0d want %0d",
                 bus.o_count, q.size());
      end
      checks++;
      if (bus.o_almost_full !== (q.size() >= AfTh)
          || bus.o_full !== (q.size() == Depth)) begin
        failures++;
        $display("FAIL fill_flags af/full got %b%b n=%0d",
                 bus.o_almost_full, bus.o_full, q.size());
      end
    end
    checks++;
    if (bus.o_overflow !== m_ovf) begin
      failures++;
      $display("FAIL fill_overflow got %b want %b",
               bus.o_overflow, m_ovf);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= Depth; i++) begin
      checks++;
      if (bus.o_rd_data !== 8'(i)) begin
        failures++;
        $display("FAIL drain_data got %h want %h",
                 bus.o_rd_data, 8'(i));
      end
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== 4'd0) begin
      failures++;
      $display("FAIL drain_empty got %b/%0d want 1/0",
               bus.o_empty, bus.o_count);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.o_underflow !== m_unf) begin
      failures++;
      $display("FAIL drain_underflow got %b want %b",
               bus.o_underflow, m_unf);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
      failures++;
      $display("FAIL err_clr got %b%b want 00",
               bus.o_overflow, bus.o_underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.o_rd_data !== q[0]) begin
        failures++;
        $display("FAIL wrap_data got %h want %h",
                 bus.o_rd_data, q[0]);
      end
      drive_cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.o_count !== 4'd3) begin
        failures++;
        $display("FAIL wrap_count got %0d want 3", bus.o_count);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] nxt;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 4'd1 || bus.o_rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL empty_wr_rd got %0d/%h want 1/a5",
               bus.o_count, bus.o_rd_data);
    end
    checks++;
    if (bus.o_underflow !== 1'b0) begin
      failures++;
      $display("FAIL empty_wr_rd_unf got %b want 0",
               bus.o_underflow);
    end
    while (q.size() < Depth) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    nxt = q[1];
    drive_cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.o_count !== 4'd8 || bus.o_rd_data !== nxt) begin
      failures++;
      $display("FAIL full_wr_rd got %0d/%h want 8/%h",
               bus.o_count, bus.o_rd_data, nxt);
    end
    checks++;
    if (bus.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_wr_rd_ovf got %b want 0",
               bus.o_overflow);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (bus.o_count !== 4'd5) begin
      failures++;
      $display("FAIL flush_pre got %0d want 5", bus.o_count);
    end
    drive_cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.o_count !== 4'd0 || bus.o_empty !== 1'b1) begin
      failures++;
      $display("FAIL flush_count got %0d/%b want 0/1",
               bus.o_count, bus.o_empty);
    end
    checks++;
    if (bus.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL flush_ovf got %b want 0", bus.o_overflow);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    bus.i_wr_en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    checks++;
    if (bus.o_count !== 4'd0 || bus.o_empty !== 1'b1
        || bus.o_full !== 1'b0) begin
      failures++;
      $display("FAIL arst_count got %0d/%b%b want 0/10",
               bus.o_count, bus.o_empty, bus.o_full);
    end
    checks++;
    if (bus.o_almost_empty !== 1'b1
        || bus.o_almost_full !== 1'b0) begin
      failures++;
      $display("FAIL arst_almost got %b%b want 10",
               bus.o_almost_empty, bus.o_almost_full);
    end
    checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin
      failures++;
      $display("FAIL arst_err got %b%b want 00",
               bus.o_overflow, bus.o_underflow);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit wr;
    bit rd;
    bit fl;
    bit clr;
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom % 3) != 0;
      rd  = ($urandom % 2) != 0;
      fl  = ($urandom % 20) == 0;
      clr = ($urandom % 10) == 0;
      drive_cycle(wr, 8'($urandom), rd, fl, clr);
      checks++;
      if (bus.o_count !== 4'(q.size())
          || bus.o_full !== (q.size() == Depth)
          || bus.o_empty !== (q.size() == 0)) begin
        failures++;
        $display("FAIL rnd_count got %0d/%b%b want %0d",
                 bus.o_count, bus.o_full, bus.o_empty, q.size());
      end
      checks++;
      if (bus.o_almost_full !== (q.size() >= AfTh)
          || bus.o_almost_empty !== (q.size() <= AeTh)) begin
        failures++;
        $display("FAIL rnd_almost got %b%b n=%0d",
                 bus.o_almost_full, bus.o_almost_empty, q.size());
      end
      checks++;
      if (bus.o_overflow !== m_ovf
          || bus.o_underflow !== m_unf) begin
        failures++;
        $display("FAIL rnd_err got %b%b want %b%b",
                 bus.o_overflow, bus.o_underflow, m_ovf, m_unf);
      end
      if (q.size() != 0) begin
        checks++;
        if (bus.o_rd_data !== q[0]) begin
          failures++;
          $display("FAIL rnd_data got %h want %h",
                   bus.o_rd_data, q[0]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
